add2_sum_accumulator: RTL and testbench
=======================================

Name: add2_sum_accumulator

Overview:
- Downstream consumer of the 2-bit adder.
- Takes the adder's 2-bit sum as a stream of samples using a valid/ready handshake.
- Accumulates NUM_SAMPLES samples into a wider register, then presents the block total on a valid/ready output.
- Sits between the ADD2 combinational stage and any result sink, such as a display driver or a register file.

Parameters:
- NUM_SAMPLES, 4, samples per accumulation block (>=1).
- ACC_W, 6, accumulator and output width in bits (>=2).
- CNT_W, 3, sample counter width; must satisfy 2^CNT_W > NUM_SAMPLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- clr  in  1  synchronous block abort/restart, active-high.
- sum  in  2  sample from the 2-bit adder's sum output.
- sumValid  in  1  sum holds a valid sample.
- sumReady  out  1  block can accept a sample this cycle.
- accOut  out  ACC_W  running total; the final block total while accValid=1.
- accValid  out  1  block total available.
- accReady  in  1  sink accepts the total.
- ovf  out  1  sticky overflow flag for the current block.
- sampleCnt  out  CNT_W  samples accepted in the current block.

Behaviour:
- Reset: on a clk edge with rst=0, state=IDLE, accOut=0, accValid=0, ovf=0, sampleCnt=0. rst overrides clr and all handshakes.
- FSM states: IDLE, ACCUM, DONE.
  - IDLE: accumulator cleared. First accepted sample moves to ACCUM, or to DONE if NUM_SAMPLES=1.
  - ACCUM: each accepted sample adds to the total. The accept with sampleCnt=NUM_SAMPLES-1 moves to DONE.
  - DONE: accValid=1. When accValid&&accReady, return to IDLE and clear accOut, ovf and sampleCnt.
- sumReady is combinational: 1 in IDLE or ACCUM with clr=0; 0 in DONE or when clr=1. It is 1 in the first cycle after reset release.
- Accept condition is sumValid&&sumReady. On accept:
  - accOut <= accOut + zero-extended sum (ACC_W bits).
  - sampleCnt <= sampleCnt+1.
- Latency: accValid rises on the clk edge of the final accept. It is high in the cycle following the last sample.
- No accept is possible in DONE, so the minimum block period is NUM_SAMPLES+1 cycles.
- Backpressure: while accValid=1 and accReady=0, accOut, ovf and sampleCnt hold stable, and sumValid is ignored.
- Gaps: cycles with sumValid=0 leave all state unchanged.
- Overflow: a carry out of bit ACC_W-1 on an accept sets ovf. ovf stays set until the output handshake, clr or reset.
  - Default behaviour wraps: the result is taken modulo 2^ACC_W.
- clr=1 (and rst=1): next state is IDLE with accOut=0, sampleCnt=0, ovf=0, accValid=0.
  - A sample presented in the same cycle is not accepted.
  - In DONE, clr discards an undelivered total.
- accReady asserted outside DONE has no effect.
- sampleCnt reads NUM_SAMPLES while in DONE.

Optional Feature:
- Macro: ADD2_ACC_SATURATE_EN.
- Defined: on overflow, accOut clamps to 2^ACC_W-1 and holds there for the rest of the block. ovf is still set.
- Undefined: wrap-around modulo 2^ACC_W as described above.
- Handshake, latency and ovf timing are identical in both builds.

Decomposition:
- Shared package add2_pkg:
  - ADD2_W=2 constant, the adder operand/sum width.
  - FSM state typedef with IDLE/ACCUM/DONE encodings.
- One natural sub-module: add2_acc_adder.
  - Combinational ACC_W-bit add of accumulator + zero-extended sum.
  - Provides carry-out and the saturate mux under ADD2_ACC_SATURATE_EN.
- The FSM, counter and registers stay in the top block.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with sumValid=1 -> accOut=0, accValid=0, ovf=0, sampleCnt=0. After release, sumReady=1 and no sample was accepted during reset.
2. Defaults, back-to-back sums 1,2,3,3 with a 2-cycle sumValid gap after the second sample -> cycle after the 4th accept: accValid=1, accOut=9, ovf=0, sampleCnt=4, sumReady=0. Then accReady=1 -> next cycle IDLE, accOut=0, accValid=0.
3. Backpressure: in DONE with accOut=9, hold accReady=0 for 5 cycles while sumValid=1, sum=3 -> accOut stays 9 and sumReady=0 throughout. accReady=1 then completes the handshake; the next block starts from 0.
4. ACC_W=3, sums 3,3,3,0 -> without ADD2_ACC_SATURATE_EN: accOut=1, ovf=1. With ADD2_ACC_SATURATE_EN: accOut=7, ovf=1. ovf clears after the handshake.
5. clr mid-block: accept 2,3, then clr=1 with sumValid=1, sum=1 -> next cycle accOut=0, sampleCnt=0, IDLE, sample dropped. Then four samples of 1 -> accOut=4 with accValid=1.
6. NUM_SAMPLES=1, sum=2 -> accValid=1, accOut=2 on the next cycle. Asserting rst=0 while in DONE -> accValid=0, IDLE on the following edge.

Source files
------------

// File: rtl/add2_pkg.sv
// Shared definitions for the ADD2 adder datapath and its downstream sum accumulator.
// Holds the adder sum width and the accumulator FSM state encoding.
package add2_pkg;

  localparam int ADD2_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/add2_acc_adder.sv
// Accumulator add of running total + zero-extended 2-bit sample, with carry-out (wrap, or clamp under ADD2_ACC_SATURATE_EN).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the result is registered.
module add2_acc_adder
  import add2_pkg::*;
#(
  parameter int ACC_W = 6
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [ADD2_W-1:0] sum,
  output logic [ACC_W-1:0]  result,
  output logic              carry
);

  localparam int PAD_W = ACC_W + 1 - ADD2_W;

  logic [ACC_W:0] wide_sum;

  assign wide_sum = {1'b0, acc} + {{PAD_W{1'b0}}, sum};
  assign carry    = wide_sum[ACC_W];

`ifdef ADD2_ACC_SATURATE_EN
  // Once clamped at all-ones, any further non-zero sample carries again, so the clamp holds.
  assign result = carry ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
`else
  assign result = wide_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/add2_sum_accumulator.sv
// Sums NUM_SAMPLES adder outputs into a block total with sticky overflow (clamp under ADD2_ACC_SATURATE_EN).
// Latency: accValid rises on the edge of the final accept.
// Backpressure: while the total waits for accReady, sumReady is low and all state holds.
module add2_sum_accumulator
  import add2_pkg::*;
#(
  parameter int NUM_SAMPLES = 4,
  parameter int ACC_W       = 6,
  parameter int CNT_W       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [ADD2_W-1:0] sum,
  input  logic              sumValid,
  output logic              sumReady,
  output logic [ACC_W-1:0]  accOut,
  output logic              accValid,
  input  logic              accReady,
  output logic              ovf,
  output logic [CNT_W-1:0]  sampleCnt
);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] add_result;
  logic             add_carry;
  logic             sum_accept;

  add2_acc_adder #(
    .ACC_W(ACC_W)
  ) u_adder (
    .acc   (acc_q),
    .sum   (sum),
    .result(add_result),
    .carry (add_carry)
  );

  assign sumReady   = (state_q != DONE) && !clr;
  assign sum_accept = sumValid && sumReady;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (sum_accept) begin
            acc_d   = add_result;
            cnt_d   = cnt_q + 1'b1;
            ovf_d   = ovf_q | add_carry;
            state_d = (cnt_q == CNT_W'(NUM_SAMPLES - 1)) ? DONE : ACCUM;
          end
        end
        DONE: begin
          // Delivered total: the next block starts from an empty accumulator.
          if (accReady) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign accOut    = acc_q;
  assign accValid  = (state_q == DONE);
  assign ovf       = ovf_q;
  assign sampleCnt = cnt_q;

endmodule

// File: tb/tb_add2_sum_accumulator.sv
// Directed bench for add2_sum_accumulator: default build (a), ACC_W=3 overflow (b), NUM_SAMPLES=1 (c).
module tb_add2_sum_accumulator;

  logic clk;
  int   pass_n;
  int   chk_n;

  // Instance a: defaults
  logic       a_rst, a_clr, a_sum_vld, a_sum_rdy, a_acc_vld, a_acc_rdy, a_ovf;
  logic [1:0] a_sum;
  logic [5:0] a_acc;
  logic [2:0] a_cnt;
  // Instance b: ACC_W=3
  logic       b_rst, b_clr, b_sum_vld, b_sum_rdy, b_acc_vld, b_acc_rdy, b_ovf;
  logic [1:0] b_sum;
  logic [2:0] b_acc;
  logic [2:0] b_cnt;
  // Instance c: NUM_SAMPLES=1
  logic       c_rst, c_clr, c_sum_vld, c_sum_rdy, c_acc_vld, c_acc_rdy, c_ovf;
  logic [1:0] c_sum;
  logic [5:0] c_acc;
  logic [2:0] c_cnt;

  add2_sum_accumulator u_dut_a (
    .clk(clk), .rst(a_rst), .clr(a_clr), .sum(a_sum), .sumValid(a_sum_vld),
    .sumReady(a_sum_rdy), .accOut(a_acc), .accValid(a_acc_vld), .accReady(a_acc_rdy),
    .ovf(a_ovf), .sampleCnt(a_cnt)
  );

  add2_sum_accumulator #(.NUM_SAMPLES(4), .ACC_W(3), .CNT_W(3)) u_dut_b (
    .clk(clk), .rst(b_rst), .clr(b_clr), .sum(b_sum), .sumValid(b_sum_vld),
    .sumReady(b_sum_rdy), .accOut(b_acc), .accValid(b_acc_vld), .accReady(b_acc_rdy),
    .ovf(b_ovf), .sampleCnt(b_cnt)
  );

  add2_sum_accumulator #(.NUM_SAMPLES(1), .ACC_W(6), .CNT_W(3)) u_dut_c (
    .clk(clk), .rst(c_rst), .clr(c_clr), .sum(c_sum), .sumValid(c_sum_vld),
    .sumReady(c_sum_rdy), .accOut(c_acc), .accValid(c_acc_vld), .accReady(c_acc_rdy),
    .ovf(c_ovf), .sampleCnt(c_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 0; b_rst = 0; c_rst = 0;
    a_sum_vld = 1; a_sum = 2'd3;
    b_sum_vld = 1; b_sum = 2'd3;
    c_sum_vld = 1; c_sum = 2'd3;
    step();
    step();
    chk_n++; if (a_acc !== 6'd0) $display("FAIL rst_acc accOut=%0d exp=0", a_acc); else pass_n++;
    chk_n++; if (a_acc_vld !== 1'b0) $display("FAIL rst_vld accValid=%b exp=0", a_acc_vld); else pass_n++;
    chk_n++; if (a_ovf !== 1'b0) $display("FAIL rst_ovf ovf=%b exp=0", a_ovf); else pass_n++;
    chk_n++; if (a_cnt !== 3'd0) $display("FAIL rst_cnt sampleCnt=%0d exp=0", a_cnt); else pass_n++;
    a_rst = 1; b_rst = 1; c_rst = 1;
    a_sum_vld = 0; b_sum_vld = 0; c_sum_vld = 0;
    #1;
    chk_n++; if (a_sum_rdy !== 1'b1) $display("FAIL rst_rdy sumReady=%b exp=1", a_sum_rdy); else pass_n++;
    step();
    chk_n++; if (a_cnt !== 3'd0) $display("FAIL rst_noacc sampleCnt=%0d exp=0", a_cnt); else pass_n++;
    chk_n++; if (b_acc !== 3'd0) $display("FAIL rst_b_acc accOut=%0d exp=0", b_acc); else pass_n++;
  endtask

  task automatic test_accumulate();
    a_sum_vld = 1; a_sum = 2'd1;
    step();
    chk_n++; if (a_acc !== 6'd1) $display("FAIL acc_s1 accOut=%0d exp=1", a_acc); else pass_n++;
    a_sum = 2'd2;
    step();
    chk_n++; if (a_cnt !== 3'd2) $display("FAIL acc_s2_cnt sampleCnt=%0d exp=2", a_cnt); else pass_n++;
    a_sum_vld = 0; a_sum = 2'd3;
    step();
    step();
    chk_n++; if (a_acc !== 6'd3) $display("FAIL acc_gap accOut=%0d exp=3", a_acc); else pass_n++;
    chk_n++; if (a_cnt !== 3'd2) $display("FAIL acc_gap_cnt sampleCnt=%0d exp=2", a_cnt); else pass_n++;
    a_sum_vld = 1; a_sum = 2'd3;
    step();
    chk_n++; if (a_acc_vld !== 1'b0) $display("FAIL acc_s3_vld accValid=%b exp=0", a_acc_vld); else pass_n++;
    step();
    chk_n++; if (a_acc_vld !== 1'b1) $display("FAIL acc_done_vld accValid=%b exp=1", a_acc_vld); else pass_n++;
    chk_n++; if (a_acc !== 6'd9) $display("FAIL acc_done accOut=%0d exp=9", a_acc); else pass_n++;
    chk_n++; if (a_ovf !== 1'b0) $display("FAIL acc_done_ovf ovf=%b exp=0", a_ovf); else pass_n++;
    chk_n++; if (a_cnt !== 3'd4) $display("FAIL acc_done_cnt sampleCnt=%0d exp=4", a_cnt); else pass_n++;
    chk_n++; if (a_sum_rdy !== 1'b0) $display("FAIL acc_done_rdy sumReady=%b exp=0", a_sum_rdy); else pass_n++;
  endtask

  task automatic test_backpressure();
    a_acc_rdy = 0; a_sum_vld = 1; a_sum = 2'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_n++; if (a_acc !== 6'd9 || a_sum_rdy !== 1'b0 || a_cnt !== 3'd4)
        $display("FAIL bp_hold[%0d] accOut=%0d sumReady=%b sampleCnt=%0d exp=9/0/4", i, a_acc, a_sum_rdy, a_cnt);
      else pass_n++;
    end
    a_acc_rdy = 1; a_sum_vld = 0;
    step();
    a_acc_rdy = 0;
    chk_n++; if (a_acc_vld !== 1'b0 || a_acc !== 6'd0 || a_cnt !== 3'd0)
      $display("FAIL bp_release accValid=%b accOut=%0d sampleCnt=%0d exp=0/0/0", a_acc_vld, a_acc, a_cnt);
    else pass_n++;
    chk_n++; if (a_sum_rdy !== 1'b1) $display("FAIL bp_idle_rdy sumReady=%b exp=1", a_sum_rdy); else pass_n++;
    a_sum_vld = 1; a_sum = 2'd2;
    step();
    chk_n++; if (a_acc !== 6'd2) $display("FAIL bp_newblk accOut=%0d exp=2", a_acc); else pass_n++;
  endtask

  task automatic test_clr();
    a_sum = 2'd3;
    step();
    chk_n++; if (a_acc !== 6'd5) $display("FAIL clr_pre accOut=%0d exp=5", a_acc); else pass_n++;
    a_clr = 1; a_sum = 2'd1;
    #1;
    chk_n++; if (a_sum_rdy !== 1'b0) $display("FAIL clr_rdy sumReady=%b exp=0", a_sum_rdy); else pass_n++;
    step();
    a_clr = 0;
    chk_n++; if (a_acc !== 6'd0 || a_cnt !== 3'd0)
      $display("FAIL clr_abort accOut=%0d sampleCnt=%0d exp=0/0", a_acc, a_cnt);
    else pass_n++;
    for (int i = 0; i < 4; i++) step();
    chk_n++; if (a_acc !== 6'd4 || a_acc_vld !== 1'b1)
      $display("FAIL clr_reblk accOut=%0d accValid=%b exp=4/1", a_acc, a_acc_vld);
    else pass_n++;
    a_sum_vld = 0; a_clr = 1;
    step();
    a_clr = 0;
    chk_n++; if (a_acc_vld !== 1'b0 || a_acc !== 6'd0)
      $display("FAIL clr_done accValid=%b accOut=%0d exp=0/0", a_acc_vld, a_acc);
    else pass_n++;
  endtask

  task automatic test_overflow();
    logic [2:0] exp_acc;
`ifdef ADD2_ACC_SATURATE_EN
    exp_acc = 3'd7;
`else
    exp_acc = 3'd1;
`endif
    b_acc_rdy = 1; b_sum_vld = 1; b_sum = 2'd3;
    step();
    step();
    chk_n++; if (b_acc !== 3'd6 || b_ovf !== 1'b0)
      $display("FAIL ovf_pre accOut=%0d ovf=%b exp=6/0", b_acc, b_ovf);
    else pass_n++;
    b_acc_rdy = 0;
    step();
    chk_n++; if (b_ovf !== 1'b1) $display("FAIL ovf_set ovf=%b exp=1", b_ovf); else pass_n++;
    b_sum = 2'd0;
    step();
    b_sum_vld = 0;
    chk_n++; if (b_acc !== exp_acc) $display("FAIL ovf_acc accOut=%0d exp=%0d", b_acc, exp_acc); else pass_n++;
    chk_n++; if (b_ovf !== 1'b1 || b_acc_vld !== 1'b1)
      $display("FAIL ovf_done ovf=%b accValid=%b exp=1/1", b_ovf, b_acc_vld);
    else pass_n++;
    b_acc_rdy = 1;
    step();
    b_acc_rdy = 0;
    chk_n++; if (b_ovf !== 1'b0 || b_acc !== 3'd0)
      $display("FAIL ovf_clear ovf=%b accOut=%0d exp=0/0", b_ovf, b_acc);
    else pass_n++;
  endtask

  task automatic test_single();
    c_sum_vld = 1; c_sum = 2'd2;
    step();
    chk_n++; if (c_acc_vld !== 1'b1 || c_acc !== 6'd2)
      $display("FAIL single_done accValid=%b accOut=%0d exp=1/2", c_acc_vld, c_acc);
    else pass_n++;
    chk_n++; if (c_cnt !== 3'd1 || c_sum_rdy !== 1'b0)
      $display("FAIL single_cnt sampleCnt=%0d sumReady=%b exp=1/0", c_cnt, c_sum_rdy);
    else pass_n++;
    c_rst = 0;
    step();
    c_rst = 1; c_sum_vld = 0;
    chk_n++; if (c_acc_vld !== 1'b0 || c_acc !== 6'd0 || c_cnt !== 3'd0)
      $display("FAIL single_rst accValid=%b accOut=%0d sampleCnt=%0d exp=0/0/0", c_acc_vld, c_acc, c_cnt);
    else pass_n++;
    #1;
    chk_n++; if (c_sum_rdy !== 1'b1) $display("FAIL single_idle_rdy sumReady=%b exp=1", c_sum_rdy); else pass_n++;
  endtask

  initial begin
    pass_n = 0; chk_n = 0;
    a_rst = 0; a_clr = 0; a_sum = 0; a_sum_vld = 0; a_acc_rdy = 0;
    b_rst = 0; b_clr = 0; b_sum = 0; b_sum_vld = 0; b_acc_rdy = 0;
    c_rst = 0; c_clr = 0; c_sum = 0; c_sum_vld = 0; c_acc_rdy = 0;
    #2;
    test_reset();
    test_accumulate();
    test_backpressure();
    test_clr();
    test_overflow();
    test_single();
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule
